// File: rtl/direction_queue_controller_if.sv
// rtl/direction_queue_controller_if.sv - shared direction/state types and the port bundle for direction_queue_controller
`ifndef TICK
`define TICK 16
`endif

package direction_queue_controller_pkg;
  // Opposite headings differ only in bit 0.
  typedef enum logic [1:0] {up = 2'd0, down = 2'd1, left = 2'd2, right = 2'd3} direction_t;
  typedef enum logic [1:0] {initial_state, game_state, pause_state, lose_state} state_t;
endpackage

interface direction_queue_controller_if #(
  parameter int QUEUE_DEPTH = 2
);
  import direction_queue_controller_pkg::*;

  state_t                       state;
  logic [$clog2(`TICK)-1:0]     ms_count;
  logic                         btn_up;
  logic                         btn_down;
  logic                         btn_left;
  logic                         btn_right;
  direction_t                   direction;
  logic                         dir_changed;
  logic [$clog2(QUEUE_DEPTH):0] queue_count;

  modport master (
    output state, ms_count, btn_up, btn_down, btn_left, btn_right,
    input  direction, dir_changed, queue_count
  );

  modport slave (
    input  state, ms_count, btn_up, btn_down, btn_left, btn_right,
    output direction, dir_changed, queue_count
  );
endinterface

// File: rtl/direction_queue_controller.sv
// rtl/direction_queue_controller.sv - debounced buttons to a queued, one-change-per-tick snake heading
// Optional: define REVERSE_GUARD_EN to reject 180-degree reversal requests.
module direction_queue_controller
  import direction_queue_controller_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter int          QUEUE_DEPTH     = 2,
  parameter direction_t  INIT_DIR        = right
) (
  input logic                     clock,
  input logic                     reset,
  direction_queue_controller_if.slave bus
);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int MS_W  = $clog2(`TICK);
  localparam logic [MS_W-1:0]  LAST_PHASE = MS_W'(`TICK - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(QUEUE_DEPTH - 1);

  // Button vectors are indexed by direction_t value, so bit 0 (up) has top priority.
  logic [3:0]  btn_raw;
  logic [3:0]  sync_1;
  logic [3:0]  sync_2;
  logic [3:0]  level;
  logic [3:0]  press_evt;
  logic [19:0] deb_cnt [4];

  assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1    <= '0;
      sync_2    <= '0;
      level     <= '0;
      press_evt <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      for (int i = 0; i < 4; i++) begin
        press_evt[i] <= 1'b0;
        if (sync_2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
          level[i]     <= ~level[i];
          deb_cnt[i]   <= '0;
          press_evt[i] <= ~level[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  logic             req_valid;
  direction_t       req_dir;
  direction_t       fifo [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  direction_t       dir_q;
  logic             changed_q;
  direction_t       ref_dir;
  logic             reversal;
  logic             pop;
  logic             push;

  always_comb begin
    req_valid = |press_evt;
    req_dir   = right;
    if (press_evt[0])      req_dir = up;
    else if (press_evt[1]) req_dir = down;
    else if (press_evt[2]) req_dir = left;
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  // With one entry the tail is also the head being popped, so it stays the reference.
  always_comb begin
    tail_ptr = (wr_ptr == '0) ? LAST_SLOT : wr_ptr - PTR_W'(1);
    ref_dir  = (count != '0) ? fifo[tail_ptr] : dir_q;
`ifdef REVERSE_GUARD_EN
    reversal = (req_dir == direction_t'(ref_dir ^ 2'b01));
`else
    reversal = 1'b0;
`endif
    pop  = (bus.state == game_state) && (bus.ms_count == LAST_PHASE) && (count != '0);
    push = req_valid && (bus.state != initial_state) && (req_dir != ref_dir) && !reversal
           && ((count != FULL_COUNT) || pop);
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= req_dir;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dir_q     <= INIT_DIR;
      changed_q <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (bus.state == initial_state) begin
      dir_q     <= INIT_DIR;
      changed_q <= (dir_q != INIT_DIR);
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      changed_q <= pop;
      if (pop) begin
        dir_q  <= fifo[rd_ptr];
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign bus.direction   = dir_q;
  assign bus.dir_changed = changed_q;
  assign bus.queue_count = count;
endmodule

// File: tb/tb_direction_queue_controller.sv
// tb/tb_direction_queue_controller.sv - directed self-checking bench for direction_queue_controller
module tb_direction_queue_controller;
  import direction_queue_controller_pkg::*;

  localparam int MS_W = $clog2(`TICK);
  localparam logic [MS_W-1:0] LAST_PHASE = MS_W'(`TICK - 1);

  logic clock = 1'b0;
  logic reset;
  logic free_run;
  int   checks = 0;
  int   errors = 0;

  direction_queue_controller_if #(.QUEUE_DEPTH(2)) bus ();

  direction_queue_controller #(
    .DEBOUNCE_CYCLES(20'd4),
    .QUEUE_DEPTH(2),
    .INIT_DIR(right)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (free_run) bus.ms_count = (bus.ms_count == LAST_PHASE) ? '0 : bus.ms_count + MS_W'(1);
  endtask

  task automatic set_btn(input direction_t d, input logic v);
    case (d)
      up:      bus.btn_up    = v;
      down:    bus.btn_down  = v;
      left:    bus.btn_left  = v;
      default: bus.btn_right = v;
    endcase
  endtask

  // Press lands in the queue on the 7th edge; the tail lets the release debounce settle.
  task automatic press(input direction_t d);
    set_btn(d, 1'b1);
    repeat (6) step();
    set_btn(d, 1'b0);
    repeat (8) step();
  endtask

  task automatic press_at_commit(input direction_t d);
    set_btn(d, 1'b1);
    repeat (6) step();
    set_btn(d, 1'b0);
    bus.ms_count = LAST_PHASE;
    step();
    bus.ms_count = '0;
  endtask

  task automatic commit_check(input string tag, input direction_t exp_dir, input int exp_pulse,
                              input int exp_count);
    bus.ms_count = LAST_PHASE;
    step();
    check({tag, "_dir"}, int'(bus.direction), int'(exp_dir));
    check({tag, "_pulse"}, int'(bus.dir_changed), exp_pulse);
    check({tag, "_count"}, int'(bus.queue_count), exp_count);
    bus.ms_count = '0;
    step();
    check({tag, "_pulse_end"}, int'(bus.dir_changed), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int bad_dir;
    reset         = 1'b1;
    free_run      = 1'b0;
    bus.state     = game_state;
    bus.ms_count  = '0;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    #2;
    check("reset_dir", int'(bus.direction), int'(right));
    check("reset_pulse", int'(bus.dir_changed), 0);
    check("reset_count", int'(bus.queue_count), 0);
    step();
    reset = 1'b0;
    step();

    // Idle game: free-running tick, nothing should move.
    free_run = 1'b1;
    pulses   = 0;
    bad_dir  = 0;
    repeat (64) begin
      step();
      if (bus.dir_changed) pulses++;
      if (bus.direction != right) bad_dir++;
    end
    check("idle_pulses", pulses, 0);
    check("idle_dir_errs", bad_dir, 0);
    check("idle_count", int'(bus.queue_count), 0);
    free_run     = 1'b0;
    bus.ms_count = '0;

    // Three-cycle glitch stays below the debounce threshold.
    set_btn(up, 1'b1);
    repeat (3) step();
    set_btn(up, 1'b0);
    repeat (10) step();
    check("glitch_count", int'(bus.queue_count), 0);
    commit_check("glitch", right, 0, 0);

    // Press latency: event after edge 6, queued on edge 7.
    set_btn(up, 1'b1);
    repeat (6) step();
    check("latency_before", int'(bus.queue_count), 0);
    set_btn(up, 1'b0);
    step();
    check("latency_push", int'(bus.queue_count), 1);
    repeat (7) step();
    commit_check("up_commit", up, 1, 0);

    press(up);
    check("noop_reject", int'(bus.queue_count), 0);
    press(right);
    check("right_queued", int'(bus.queue_count), 1);
    commit_check("right_commit", right, 1, 0);

    // Two presses within one tick commit on successive boundaries.
    press(up);
    press(left);
    check("double_count", int'(bus.queue_count), 2);
    commit_check("double_first", up, 1, 1);
    commit_check("double_second", left, 1, 0);

    bus.state = initial_state;
    step();
    check("init_dir", int'(bus.direction), int'(right));
    check("init_pulse", int'(bus.dir_changed), 1);
    check("init_count", int'(bus.queue_count), 0);
    press(up);
    check("init_ignore_count", int'(bus.queue_count), 0);
    check("init_no_repulse", int'(bus.dir_changed), 0);
    bus.state = game_state;
    step();

    press(left);
`ifdef REVERSE_GUARD_EN
    check("reverse_count", int'(bus.queue_count), 0);
    commit_check("reverse", right, 0, 0);
`else
    check("reverse_count", int'(bus.queue_count), 1);
    commit_check("reverse", left, 1, 0);
    bus.state = initial_state;
    step();
    bus.state = game_state;
    step();
`endif

    // Full queue drops a request; full plus pop accepts it.
    press(up);
    press(left);
    press(down);
    check("full_drop_count", int'(bus.queue_count), 2);
    press_at_commit(down);
    check("fullpop_dir", int'(bus.direction), int'(up));
    check("fullpop_pulse", int'(bus.dir_changed), 1);
    check("fullpop_count", int'(bus.queue_count), 2);
    repeat (7) step();
    commit_check("fullpop_second", left, 1, 1);
    commit_check("fullpop_third", down, 1, 0);

    // Single entry being popped is still the reference for a same-cycle push.
    press(left);
    check("single_count", int'(bus.queue_count), 1);
    press_at_commit(left);
    check("single_pop_dir", int'(bus.direction), int'(left));
    check("single_pop_count", int'(bus.queue_count), 0);
    repeat (7) step();

    // Paused: requests queue but nothing commits.
    bus.state = pause_state;
    press(up);
    check("pause_count", int'(bus.queue_count), 1);
    bus.ms_count = LAST_PHASE;
    step();
    check("pause_hold_dir", int'(bus.direction), int'(left));
    check("pause_hold_pulse", int'(bus.dir_changed), 0);
    check("pause_hold_count", int'(bus.queue_count), 1);
    bus.ms_count = '0;
    bus.state    = game_state;
    step();
    commit_check("pause_resume", up, 1, 0);

    press(left);
    press(down);
    press(right);
    check("full_drop2_count", int'(bus.queue_count), 2);
    bus.state = initial_state;
    step();
    check("flush_count", int'(bus.queue_count), 0);
    check("flush_dir", int'(bus.direction), int'(right));
    check("flush_pulse", int'(bus.dir_changed), 1);
    step();
    check("flush_pulse_once", int'(bus.dir_changed), 0);
    bus.state = game_state;
    step();

    // Asynchronous reset clears state between clock edges.
    press(up);
    commit_check("pre_reset", up, 1, 0);
    press(left);
    check("pre_reset_count", int'(bus.queue_count), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_dir", int'(bus.direction), int'(right));
    check("async_reset_count", int'(bus.queue_count), 0);
    step();
    reset = 1'b0;
    step();
    press(up);
    check("post_reset_count", int'(bus.queue_count), 1);
    commit_check("post_reset", up, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
